// File: rtl/color_pkg.sv
// Shared definitions for the colour palette block.
//   DEFAULT_COLOR  colour for unused palette slots and out-of-range tile values
//   rgb_t          8-bit-per-channel view of a 24-bit pixel (R in MSBs)
//   default_entry  power-up palette contents, indexed by entry number
//   sat_add        saturating add of a channel value, generic in channel width
package color_pkg;

    localparam logic [23:0] DEFAULT_COLOR = 24'hE0E0E0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic logic [23:0] default_entry(input int idx);
        case (idx)
            0:       return 24'hC0C0C0;
            1:       return 24'hFF99CC;
            2:       return 24'hCC99FF;
            3:       return 24'h9999FF;
            4:       return 24'h99CCFF;
            5:       return 24'h99FFFF;
            6:       return 24'h99FFCC;
            7:       return 24'h99FF99;
            8:       return 24'hCCFF99;
            9:       return 24'hFFFF99;
            10:      return 24'hFFCCFF;
            11:      return 24'hFF9999;
            default: return DEFAULT_COLOR;
        endcase
    endfunction

    // Returns min(a + b, 2**ch_w - 1). The sum is kept one bit wider so it cannot wrap.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int ch_w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << ch_w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/palette_regfile.sv
// Palette storage: ENTRIES flops of COLOR_W bits, async reset to the default palette.
//   clk, rst_n   pixel clock, async active-low reset
//   wr_en_i      write strobe; wr_addr_i >= ENTRIES matches no slot and is dropped
//   wr_addr_i    entry to write
//   wr_data_i    new colour
//   rd_addr_i    lookup address; out-of-range returns DEFAULT_COLOR
//   rd_data_o    combinational lookup result (old value during a same-cycle write)
//   bg_o         entry 0, used as the background colour
module palette_regfile
    import color_pkg::*;
#(
    parameter int VALUE_W = 4,
    parameter int ENTRIES = 16,
    parameter int COLOR_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en_i,
    input  logic [VALUE_W-1:0] wr_addr_i,
    input  logic [COLOR_W-1:0] wr_data_i,
    input  logic [VALUE_W-1:0] rd_addr_i,
    output logic [COLOR_W-1:0] rd_data_o,
    output logic [COLOR_W-1:0] bg_o
);

    logic [COLOR_W-1:0] mem_q [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= COLOR_W'(default_entry(i));
            end
        end else if (wr_en_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (wr_addr_i == VALUE_W'(i)) begin
                    mem_q[i] <= wr_data_i;
                end
            end
        end
    end

    // Address decode by comparison keeps the read safe when ENTRIES < 2**VALUE_W.
    always_comb begin
        rd_data_o = COLOR_W'(DEFAULT_COLOR);
        for (int i = 0; i < ENTRIES; i++) begin
            if (rd_addr_i == VALUE_W'(i)) begin
                rd_data_o = mem_q[i];
            end
        end
    end

    assign bg_o = mem_q[0];

endmodule

// File: rtl/color_palette.sv
// Pipelined programmable palette between the tile generator and the VGA DAC.
// Maps a tile value to a colour with blanking, highlight and frame-based blink,
// and delays valid/hsync/vsync by the same 2 cycles as the colour.
//   clk, rst_n                 pixel clock, async active-low reset
//   pix_valid_in, value_in     pixel stream in (one pixel per clock, no backpressure)
//   blink_in, hl_in, blank_in  per-pixel attributes
//   hsync_in, vsync_in         active-low syncs; vsync falling edge is the frame tick
//   wr_en, wr_addr, wr_data    palette write port
//   pix_valid_out, pixel_color, hsync_out, vsync_out   stream out, 2 cycles later
//   blink_phase                1 = blinking pixels currently replaced by background
// Stream semantics: pix_valid_in qualifies value_in and flags in the same cycle; there is
// no ready, every cycle advances the pipeline, and invalid cycles emit colour 0.
module color_palette
    import color_pkg::*;
#(
    parameter int VALUE_W      = 4,
    parameter int ENTRIES      = 16,
    parameter int COLOR_W      = 24,
    parameter int HL_OFFSET    = 32,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_valid_in,
    input  logic [VALUE_W-1:0] value_in,
    input  logic               blink_in,
    input  logic               hl_in,
    input  logic               blank_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               wr_en,
    input  logic [VALUE_W-1:0] wr_addr,
    input  logic [COLOR_W-1:0] wr_data,
    output logic               pix_valid_out,
    output logic [COLOR_W-1:0] pixel_color,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               blink_phase
);

    localparam int CH_W   = COLOR_W / 3;
    localparam int FCNT_W = $clog2(BLINK_FRAMES + 1);

    logic [COLOR_W-1:0] rd_color;
    logic [COLOR_W-1:0] bg_color;

    palette_regfile #(
        .VALUE_W (VALUE_W),
        .ENTRIES (ENTRIES),
        .COLOR_W (COLOR_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (value_in),
        .rd_data_o (rd_color),
        .bg_o      (bg_color)
    );

    // Stage 1: looked-up colours plus flags and syncs.
    logic [COLOR_W-1:0] col_q, bg_q;
    logic               valid_q, blink_q, hl_q, blank_q, hs1_q, vs1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            bg_q    <= '0;
            valid_q <= 1'b0;
            blink_q <= 1'b0;
            hl_q    <= 1'b0;
            blank_q <= 1'b0;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
        end else begin
            col_q   <= rd_color;
            bg_q    <= bg_color;
            valid_q <= pix_valid_in;
            blink_q <= blink_in;
            hl_q    <= hl_in;
            blank_q <= blank_in;
            hs1_q   <= hsync_in;
            vs1_q   <= vsync_in;
        end
    end

    // Blink timing: one tick per vsync falling edge, phase flips every BLINK_FRAMES ticks.
    logic              vs_prev_q;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic              phase_q, phase_d;
    logic              frame_tick;

    assign frame_tick = vs_prev_q & ~vsync_in;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (frame_tick) begin
            if (frame_cnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q   <= 1'b1;
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            vs_prev_q   <= vsync_in;
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
        end
    end

    // Stage 2: final colour selection, blank over blink over highlight.
    logic [COLOR_W-1:0] hl_color;
    logic [COLOR_W-1:0] pixel_d;
    logic [COLOR_W-1:0] pixel_q;
    logic               valid2_q, hs2_q, vs2_q;

    always_comb begin
        hl_color = '0;
        for (int c = 0; c < 3; c++) begin
            hl_color[c*CH_W +: CH_W] =
                CH_W'(sat_add(32'(col_q[c*CH_W +: CH_W]), 32'(HL_OFFSET), CH_W));
        end
        pixel_d = col_q;
        if (!valid_q || blank_q) begin
            pixel_d = '0;
        end else if (blink_q && phase_q) begin
            pixel_d = bg_q;  // hidden blinking pixel shows background, never highlighted
        end else if (hl_q) begin
            pixel_d = hl_color;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_q  <= '0;
            valid2_q <= 1'b0;
            hs2_q    <= 1'b1;
            vs2_q    <= 1'b1;
        end else begin
            pixel_q  <= pixel_d;
            valid2_q <= valid_q;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
        end
    end

    assign pixel_color   = pixel_q;
    assign pix_valid_out = valid2_q;
    assign hsync_out     = hs2_q;
    assign vsync_out     = vs2_q;
    assign blink_phase   = phase_q;

endmodule

// File: tb/tb_color_palette.sv
// Directed bench for color_palette (ENTRIES=12, BLINK_FRAMES=2, HL_OFFSET=32).
module tb_color_palette;

    localparam int VALUE_W      = 4;
    localparam int ENTRIES      = 12;
    localparam int COLOR_W      = 24;
    localparam int HL_OFFSET    = 32;
    localparam int BLINK_FRAMES = 2;

    // Clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               pix_valid_in;
    logic [VALUE_W-1:0] value_in;
    logic               blink_in, hl_in, blank_in, hsync_in, vsync_in;
    logic               wr_en;
    logic [VALUE_W-1:0] wr_addr;
    logic [COLOR_W-1:0] wr_data;
    logic               pix_valid_out;
    logic [COLOR_W-1:0] pixel_color;
    logic               hsync_out, vsync_out, blink_phase;

    color_palette #(
        .VALUE_W      (VALUE_W),
        .ENTRIES      (ENTRIES),
        .COLOR_W      (COLOR_W),
        .HL_OFFSET    (HL_OFFSET),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pix_valid_in  (pix_valid_in),
        .value_in      (value_in),
        .blink_in      (blink_in),
        .hl_in         (hl_in),
        .blank_in      (blank_in),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .pix_valid_out (pix_valid_out),
        .pixel_color   (pixel_color),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out),
        .blink_phase   (blink_phase)
    );

    // Scoreboard: one expected output record per driven cycle.
    typedef struct packed {
        logic [COLOR_W-1:0] col;
        logic               valid;
        logic               hs;
        logic               vs;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Drive one pixel at a negedge, advance one clock, then compare the output
    // against the record pushed two cycles earlier.
    task automatic cycle(input string tag, input logic v, input logic [VALUE_W-1:0] val,
                         input logic bl, input logic hl, input logic bk,
                         input logic hs, input logic vs, input logic [COLOR_W-1:0] exp_col);
        exp_t e;
        pix_valid_in = v;
        value_in     = val;
        blink_in     = bl;
        hl_in        = hl;
        blank_in     = bk;
        hsync_in     = hs;
        vsync_in     = vs;
        e.col   = v ? exp_col : '0;
        e.valid = v;
        e.hs    = hs;
        e.vs    = vs;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check({tag, "_color"}, 32'(pixel_color), 32'(e.col));
            check({tag, "_valid"}, 32'(pix_valid_out), 32'(e.valid));
            check({tag, "_hsync"}, 32'(hsync_out), 32'(e.hs));
            check({tag, "_vsync"}, 32'(vsync_out), 32'(e.vs));
        end
    endtask

    task automatic pix(input string tag, input logic [VALUE_W-1:0] val,
                       input logic [COLOR_W-1:0] exp_col);
        cycle(tag, 1'b1, val, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, exp_col);
    endtask

    task automatic idle();
        cycle("idle", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    endtask

    // Assert reset at the current negedge, check outputs immediately, release later.
    task automatic do_reset(input string tag);
        exp_t e;
        rst_n = 1'b0;
        #1;
        check({tag, "_color"}, 32'(pixel_color), 32'h0);
        check({tag, "_valid"}, 32'(pix_valid_out), 32'h0);
        check({tag, "_hsync"}, 32'(hsync_out), 32'h1);
        check({tag, "_vsync"}, 32'(vsync_out), 32'h1);
        check({tag, "_phase"}, 32'(blink_phase), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        // The first output after release comes from the reset-state stage 1.
        e.col   = '0;
        e.valid = 1'b0;
        e.hs    = 1'b1;
        e.vs    = 1'b1;
        exp_q.push_back(e);
    endtask

    logic [23:0] sweep_tbl [16];
    logic [15:0] v_pat, h_pat, vs_pat;

    initial begin
        sweep_tbl = '{24'hC0C0C0, 24'hFF99CC, 24'hCC99FF, 24'h9999FF,
                      24'h99CCFF, 24'h99FFFF, 24'h99FFCC, 24'h99FF99,
                      24'hCCFF99, 24'hFFFF99, 24'hFFCCFF, 24'hFF9999,
                      24'hE0E0E0, 24'hE0E0E0, 24'hE0E0E0, 24'hE0E0E0};
        pix_valid_in = 1'b0;
        value_in     = '0;
        blink_in     = 1'b0;
        hl_in        = 1'b0;
        blank_in     = 1'b0;
        hsync_in     = 1'b1;
        vsync_in     = 1'b1;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;

        @(negedge clk);
        do_reset("reset");

        // Default palette sweep, including out-of-range values.
        for (int i = 0; i < 16; i++) pix("sweep", VALUE_W'(i), sweep_tbl[i]);
        idle();
        idle();

        // Same-cycle write returns old value; out-of-range writes are dropped.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 24'h123456;
        pix("wr_same", 4'd3, 24'h9999FF);
        pix("wr_next", 4'd3, 24'h123456);
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 24'hABCDEF;
        pix("wr15_same", 4'd15, 24'hE0E0E0);
        pix("wr15_next", 4'd15, 24'hE0E0E0);
        wr_en = 1'b1; wr_addr = 4'd12; wr_data = 24'h00FF00;
        idle();
        pix("wr12_next", 4'd12, 24'hE0E0E0);

        // Highlight and blanking.
        cycle("hl_v2",  1'b1, 4'd2,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'hECB9FF);
        cycle("hl_v11", 1'b1, 4'd11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'hFFB9B9);
        cycle("hl_v3",  1'b1, 4'd3,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h325476);
        cycle("blank",  1'b1, 4'd2,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000);
        cycle("blk_hl", 1'b1, 4'd2,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 24'h000000);
        cycle("inval",  1'b0, 4'd2,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000000);
        idle();
        idle();

        // Sync and valid patterns delayed by exactly two cycles.
        v_pat  = 16'b1011_0010_1110_0101;
        h_pat  = 16'b1100_1110_0111_0101;
        vs_pat = 16'b1110_0111_1100_1011;
        for (int i = 0; i < 16; i++) begin
            cycle("sync", v_pat[i], 4'd0, 1'b0, 1'b0, 1'b0, h_pat[i], vs_pat[i], 24'hC0C0C0);
        end
        idle();
        idle();

        // Reset mid-line after a palette write: entry returns to its default.
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 24'h010203;
        pix("rw_pre", 4'd0, 24'hC0C0C0);
        cycle("rw_a", 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h010203);
        cycle("rw_b", 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h010203);
        do_reset("mid_reset");
        pix("rst_restored", 4'd5, 24'h99FFFF);
        idle();
        idle();

        // Blink with BLINK_FRAMES=2: phase flips on the 2nd and 4th vsync fall.
        cycle("bl_on",    1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h99FF99);
        cycle("bl_on_hl", 1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'hB9FFB9);
        cycle("tick1", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("phase_t1", 32'(blink_phase), 32'h0);
        idle();
        cycle("tick2", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("phase_t2", 32'(blink_phase), 32'h1);
        idle();
        idle();
        cycle("bl_off",    1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'hC0C0C0);
        cycle("bl_off_hl", 1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'hC0C0C0);
        cycle("noblink",   1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h99FF99);
        cycle("bl_blank",  1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000);
        cycle("nobl_hl",   1'b1, 4'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'hB9FFB9);
        cycle("tick3", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("phase_t3", 32'(blink_phase), 32'h1);
        idle();
        cycle("tick4", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("phase_t4", 32'(blink_phase), 32'h0);
        idle();
        idle();
        cycle("bl_back", 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h99FF99);
        idle();
        idle();

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
